// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port, one transaction in flight.
// Accept-to-completion >= 2 cycles; requesters see ready=0 until the port is free again.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [63:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [63:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner_lsu;
  logic        last_lsu;
  logic        grant_ifu, grant_lsu;
  logic        accept;
  logic        capture;
  logic [63:0] ifu_rdata_q, lsu_rdata_q;
  logic [63:0] addr_q, wdata_q;
  logic        wen_q;
  logic [7:0]  wmask_q;

  // A tie goes to whichever requester did not win last time.
  always_comb begin
    grant_ifu = ifu_req_valid && (!lsu_req_valid || last_lsu);
    grant_lsu = lsu_req_valid && (!ifu_req_valid || !last_lsu);
    accept    = (state == IDLE) && (grant_ifu || grant_lsu);
    capture   = ((state == REQ) && mem_req_ready && mem_resp_valid) ||
                ((state == RESP) && mem_resp_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (mem_req_ready) state_nxt = mem_resp_valid ? DONE : RESP;
      RESP:    if (mem_resp_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsu   <= 1'b0;
      last_lsu    <= 1'b1;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (accept) begin
        owner_lsu <= grant_lsu;
        last_lsu  <= grant_lsu;
        addr_q    <= grant_lsu ? lsu_addr  : ifu_addr;
        wen_q     <= grant_lsu ? lsu_wen   : 1'b0;
        wdata_q   <= grant_lsu ? lsu_wdata : 64'd0;
        wmask_q   <= grant_lsu ? lsu_wmask : 8'd0;
      end
      if (capture && owner_lsu)  lsu_rdata_q <= mem_rdata;
      if (capture && !owner_lsu) ifu_rdata_q <= mem_rdata;
    end
  end

  // Handshake outputs are held low while rst is asserted so an abandoned
  // transaction can never emit a pulse in the reset cycle itself.
  always_comb begin
    ifu_req_ready  = !rst && (state == IDLE) && grant_ifu;
    lsu_req_ready  = !rst && (state == IDLE) && grant_lsu;
    mem_req_valid  = !rst && (state == REQ);
    ifu_resp_valid = !rst && (state == DONE) && !owner_lsu;
    lsu_resp_valid = !rst && (state == DONE) && owner_lsu;
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
    ifu_rdata      = ifu_rdata_q;
    lsu_rdata      = lsu_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a
// scoreboard queue, a negedge monitor pops and compares on every resp pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  typedef struct packed {
    logic        lsu;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] e_addr, e_wdata;
  logic        e_wen;
  logic [7:0]  e_wmask;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (ifu_resp_valid === 1'b1 || lsu_resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_resp", {62'd0, lsu_resp_valid, ifu_resp_valid}, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_ifu_pulse", {63'd0, ifu_resp_valid}, {63'd0, !mon_e.lsu});
        chk("sb_lsu_pulse", {63'd0, lsu_resp_valid}, {63'd0, mon_e.lsu});
        chk("sb_rdata", mon_e.lsu ? lsu_rdata : ifu_rdata, mon_e.rdata);
      end
    end
  end

  // In IDLE: check the grant, record expected payload/completion, take the accept edge.
  task automatic accept(input bit exp_lsu, input logic [63:0] rd, input bit push);
    exp_t e;
    @(negedge clk);
    chk("ifu_req_ready", {63'd0, ifu_req_ready}, {63'd0, !exp_lsu});
    chk("lsu_req_ready", {63'd0, lsu_req_ready}, {63'd0, exp_lsu});
    chk("no_resp_in_idle", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    e_addr  = exp_lsu ? lsu_addr  : ifu_addr;
    e_wen   = exp_lsu ? lsu_wen   : 1'b0;
    e_wdata = exp_lsu ? lsu_wdata : 64'd0;
    e_wmask = exp_lsu ? lsu_wmask : 8'd0;
    if (push) begin
      e.lsu   = exp_lsu;
      e.rdata = rd;
      sb_q.push_back(e);
    end
    step();
  endtask

  // In REQ: stall the port, handshake, then respond 'lat' cycles after (0 = same cycle).
  task automatic serve(input logic [63:0] rd, input int stall, input int lat);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      @(negedge clk);
      chk("stall_req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("stall_addr", mem_addr, e_addr);
      chk("stall_wdata", mem_wdata, e_wdata);
      chk("stall_wen_wmask", {55'd0, mem_wen, mem_wmask}, {55'd0, e_wen, e_wmask});
      chk("stall_readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      step();
    end
    mem_req_ready  = 1'b1;
    mem_resp_valid = (lat == 0);
    mem_rdata      = rd;
    @(negedge clk);
    chk("hs_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("hs_addr", mem_addr, e_addr);
    chk("hs_wen", {63'd0, mem_wen}, {63'd0, e_wen});
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        @(negedge clk);
        chk("wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("wait_readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        step();
      end
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      @(negedge clk);
      chk("resp_readies", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
      step();
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic done_check(input bit exp_lsu, input logic [63:0] rd);
    @(negedge clk);
    chk("done_pulses", {62'd0, ifu_resp_valid, lsu_resp_valid}, {62'd0, !exp_lsu, exp_lsu});
    chk("done_rdata", exp_lsu ? lsu_rdata : ifu_rdata, rd);
    chk("done_req_valid", {63'd0, mem_req_valid}, 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_resp_valids", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("rst_ifu_rdata", ifu_rdata, 64'd0);
    chk("rst_lsu_rdata", lsu_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    step();
    rst = 1'b0;

    // Fetch alone, fastest path: pulse two cycles after accept
    ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
    accept(1'b0, 64'h13, 1'b1);
    ifu_req_valid = 0;
    serve(64'h13, 0, 0);
    done_check(1'b0, 64'h13);

    // Tie arbitration from reset: IFU, LSU, IFU
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifu_req_valid = 1; ifu_addr = 64'h100;
    lsu_req_valid = 1; lsu_addr = 64'h200; lsu_wen = 0;
    accept(1'b0, 64'hA1, 1'b1);
    serve(64'hA1, 0, 0);
    done_check(1'b0, 64'hA1);
    accept(1'b1, 64'hB2, 1'b1);
    serve(64'hB2, 0, 0);
    done_check(1'b1, 64'hB2);
    accept(1'b0, 64'hC3, 1'b1);
    ifu_req_valid = 0; lsu_req_valid = 0;
    serve(64'hC3, 0, 0);
    done_check(1'b0, 64'hC3);

    // Store with 3 stall cycles; requester inputs change after accept
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_1000;
    lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'hFF;
    accept(1'b1, 64'h55, 1'b1);
    lsu_req_valid = 0; lsu_addr = 64'h1; lsu_wdata = 64'h2; lsu_wmask = 8'h0; lsu_wen = 0;
    serve(64'h55, 3, 1);
    done_check(1'b1, 64'h55);
    @(negedge clk);
    chk("store_keeps_ifu_rdata", ifu_rdata, 64'hC3);
    step();

    // Slow responses with the other requester waiting throughout
    ifu_req_valid = 1; ifu_addr = 64'h8000_2000;
    lsu_req_valid = 1; lsu_addr = 64'h8000_3000; lsu_wen = 0;
    accept(1'b0, 64'h1234, 1'b1);
    ifu_req_valid = 0;
    serve(64'h1234, 0, 5);
    done_check(1'b0, 64'h1234);
    accept(1'b1, 64'h9999, 1'b1);
    lsu_req_valid = 0;
    serve(64'h9999, 1, 5);
    done_check(1'b1, 64'h9999);
    @(negedge clk);
    chk("lsu_keeps_ifu_rdata", ifu_rdata, 64'h1234);
    step();

    // Spurious memory response while idle
    mem_resp_valid = 1; mem_rdata = 64'hFFFF;
    @(negedge clk);
    chk("spur_req_valid", {63'd0, mem_req_valid}, 64'd0);
    step();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("spur_no_pulse", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("spur_lsu_rdata", lsu_rdata, 64'h9999);
    chk("spur_ifu_rdata", ifu_rdata, 64'h1234);
    step();

    // Reset while waiting for the response, then a late response
    ifu_req_valid = 1; ifu_addr = 64'h40;
    accept(1'b0, 64'h0, 1'b0);
    ifu_req_valid = 0;
    mem_req_ready = 1;
    @(negedge clk);
    chk("abort_req_valid", {63'd0, mem_req_valid}, 64'd1);
    step();
    mem_req_ready = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_rst_quiet", {61'd0, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    step();
    rst = 0;
    mem_resp_valid = 1; mem_rdata = 64'hBAD;
    @(negedge clk);
    chk("late_resp_no_req", {63'd0, mem_req_valid}, 64'd0);
    step();
    mem_resp_valid = 0;
    @(negedge clk);
    chk("late_resp_no_pulse", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk("abort_ifu_rdata", ifu_rdata, 64'd0);
    chk("abort_lsu_rdata", lsu_rdata, 64'd0);
    chk("abort_mem_addr", mem_addr, 64'd0);
    ifu_req_valid = 1; lsu_req_valid = 1;
    #1;
    chk("abort_idle_tie_ifu", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
    ifu_req_valid = 0; lsu_req_valid = 0;
    step();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 ifu_req_valid  in  1  fetch request.
REQ-003 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-004 ifu_addr  in  64  fetch address.
REQ-005 ifu_resp_valid  out  1  one-cycle fetch completion pulse.
REQ-006 ifu_rdata  out  64  fetch data.
REQ-007 lsu_req_valid  in  1  load/store request.
REQ-008 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-009 lsu_addr  in  64  load/store address.
REQ-010 lsu_wen  in  1  1 = store, 0 = load.
REQ-011 lsu_wdata  in  64  store data.
REQ-012 lsu_wmask  in  8  store byte mask.
REQ-013 lsu_resp_valid  out  1  one-cycle load/store completion pulse.
REQ-014 lsu_rdata  out  64  load data.
REQ-015 mem_req_valid  out  1  request to the shared memory port.
REQ-016 mem_req_ready  in  1  memory accepts the request.
REQ-017 mem_addr / mem_wen / mem_wdata / mem_wmask  out  64/1/64/8  latched payload.
REQ-018 mem_resp_valid  in  1  memory completion (reads and writes).
REQ-019 mem_rdata  in  64  memory read data, valid with mem_resp_valid.

Function
REQ-020 The block SHALL be an FSM with states IDLE, REQ, RESP and DONE, an owner register (IFU/LSU) and a last_owner register.
REQ-021 IDLE: the block SHALL select IFU if only ifu_req_valid is high, LSU if only lsu_req_valid is high, and on a tie the requester that is not last_owner.
REQ-022 IDLE: the block SHALL assert the selected requester's *_req_ready combinationally in the same cycle; the other requester's ready SHALL be 0.
REQ-023 On acceptance, the block SHALL latch addr and, for LSU, wen/wdata/wmask (IFU: wen=0, wdata=0, wmask=0), set owner and last_owner, and go to REQ.
REQ-024 Both *_req_ready outputs SHALL be 0 in every state other than IDLE, with at most one transaction outstanding.
REQ-025 REQ: the block SHALL hold mem_req_valid=1 with a stable payload until mem_req_ready=1, then go to RESP.
REQ-026 REQ: if mem_req_ready and mem_resp_valid are both 1 in the same cycle, the block SHALL capture mem_rdata and go directly to DONE.
REQ-027 RESP: when mem_resp_valid=1, the block SHALL register mem_rdata into the owner's rdata register and go to DONE.
REQ-028 mem_resp_valid SHALL be ignored in IDLE, DONE, and in REQ before the handshake.
REQ-029 DONE: the block SHALL assert the owner's *_resp_valid for exactly one cycle, then go to IDLE.
REQ-030 Store completion SHALL also pulse lsu_resp_valid, and lsu_rdata SHALL take mem_rdata regardless of wen.
REQ-031 ifu_rdata and lsu_rdata SHALL hold their value until that requester's next completion.
REQ-032 mem_req_valid SHALL be 1 only in REQ.
REQ-033 mem_addr, mem_wen, mem_wdata and mem_wmask SHALL hold their last latched value outside REQ.
REQ-034 Minimum latency SHALL be: accept at t, mem_req_valid at t+1, resp_valid at t+2 (same-cycle ready+resp) or later.
REQ-035 Requester inputs SHALL be ignored after acceptance until the next IDLE.

Reset
REQ-036 rst=1 SHALL force: state IDLE, owner IFU, last_owner LSU (IFU wins the first tie), all valid/ready outputs 0 except the combinational ready in IDLE, rdata regs 0, mem payload regs 0.
REQ-037 rst asserted in REQ/RESP/DONE SHALL abandon the transaction with no resp pulse; a later mem_resp_valid SHALL be ignored.

Verification
REQ-038 IFU only: ifu_addr=0x8000_0000, mem_req_ready=1 and mem_resp_valid=1 with mem_rdata=0x13 one cycle after acceptance -> mem_addr=0x8000_0000, mem_wen=0, ifu_resp_valid pulse at t+2, ifu_rdata=0x13.
REQ-039 Tie after reset: both valid at t -> IFU granted at t; hold both -> LSU granted on the next IDLE; alternation continues.
REQ-040 Store: lsu_wen=1, addr=0x8000_1000, wdata=0xDEADBEEF, wmask=0xFF, mem_req_ready stalled 3 cycles -> payload stable 3 cycles, lsu_resp_valid one pulse after mem_resp_valid, no ifu pulse.
REQ-041 Slow response: mem_resp_valid arrives 5 cycles after the handshake -> both readies 0 throughout, a single resp pulse, ifu_rdata unchanged by an LSU transaction.
REQ-042 Reset mid-RESP: rst for 1 cycle, then mem_resp_valid=1 -> no resp pulse, state IDLE, rdata=0.
REQ-043 Spurious mem_resp_valid in IDLE -> no state change, no pulse.
